memfifo_checker: RTL

- Receiver and verifier for the memfifo 16-bit test-data stream.
- Consumes the words the FIFO delivers with a valid/ready handshake, aligns itself to the 8-word block structure, and checks every word against the expected counter pattern and block checksum.
- Reports lock state, word, block and error counts for LEDs or debug readout.
- Sits on the ifclk domain, on the FIFO output side, in place of (or in parallel with) the EZ-USB transmit path.

---
 rtl/memfifo_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/memfifo_checker.sv
// memfifo_checker: aligns to and verifies the memfifo 16-bit test stream.
// Define MEMFIFO_CHECKER_CAPTURE_EN to add first-mismatch capture outputs.
module memfifo_checker #(
  parameter int          LOSS_THRESHOLD = 4,
  parameter logic [13:0] CS_INIT        = 14'd47
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] DI,
  input  logic        DI_valid,
  output logic        DI_ready,
  output logic        locked,
  output logic [31:0] word_cnt,
  output logic [31:0] block_cnt,
  output logic [15:0] err_cnt,
  output logic [3:0]  status
`ifdef MEMFIFO_CHECKER_CAPTURE_EN
  ,
  output logic [15:0] first_err_got,
  output logic [15:0] first_err_exp,
  output logic [34:0] first_err_idx
`endif
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [7:0] LOSS   = 8'(LOSS_THRESHOLD);

  logic [1:0]  state;
  logic [6:0]  b;
  logic [2:0]  k;
  logic [13:0] cs;
  logic        blk_ok;
  logic [7:0]  bad_run;
  logic        last_word_bad;
  logic        cs_bad_seen;

  logic        acc;
  logic        check;
  logic        bad;
  logic        blk_ok_cur;
  logic [6:0]  base;
  logic [6:0]  e0;
  logic [6:0]  e1;
  logic [6:0]  fold;
  logic [2:0]  kk;
  logic [13:0] cs_cur;
  logic [13:0] cs_add;
  logic [13:0] w;
  logic [15:0] exp_word;

  // Expected word and checksum for the word currently offered; in ALIGN
  // the offered word itself supplies the block base.
  always_comb begin
    acc        = DI_valid && DI_ready;
    base       = (state == ALIGN) ? DI[6:0] : b;
    kk         = (state == ALIGN) ? 3'd0 : k;
    e0         = base + ({4'd0, kk} * 7'd94);
    e1         = e0 + 7'd111;
    cs_cur     = (kk == 3'd0) ? CS_INIT : cs;
    cs_add     = cs_cur + {6'd0, 1'b1, e1} + {7'd0, e0};
    w          = cs_cur + {6'd0, 1'b1, e0};
    fold       = w[6:0] ^ w[13:7];
    exp_word   = (kk == 3'd7) ? {1'b1, fold, 1'b1, e0}
                              : {1'b1, e1, 1'b0, e0};
    check      = acc && ((state == LOCKED) ||
                         ((state == ALIGN) && !DI[7]));
    bad        = (DI != exp_word);
    blk_ok_cur = (kk == 3'd0) || blk_ok;
  end

  // Handshake, lock FSM and expected-value tracking
  always_ff @(posedge ifclk) begin
    if (reset) begin
      DI_ready <= 1'b0;
      state    <= HUNT;
      b        <= 7'd0;
      k        <= 3'd0;
      cs       <= 14'd0;
      blk_ok   <= 1'b0;
      bad_run  <= 8'd0;
    end else begin
      DI_ready <= enable;
      if (acc && (state == HUNT) && DI[7])
        state <= ALIGN;
      if (check) begin
        state  <= LOCKED;
        b      <= (kk == 3'd7) ? base + 7'd1 : base;
        k      <= kk + 3'd1;
        cs     <= cs_add;
        blk_ok <= blk_ok_cur && !bad;
        if (!bad) begin
          bad_run <= 8'd0;
        end else if (bad_run + 8'd1 >= LOSS) begin
          state   <= HUNT;
          bad_run <= 8'd0;
        end else begin
          bad_run <= bad_run + 8'd1;
        end
      end
    end
  end

  // Statistics; clear overrides any event in the same cycle
  always_ff @(posedge ifclk) begin
    if (reset || clear) begin
      word_cnt      <= 32'd0;
      block_cnt     <= 32'd0;
      err_cnt       <= 16'd0;
      last_word_bad <= 1'b0;
      cs_bad_seen   <= 1'b0;
    end else if (check) begin
      word_cnt      <= word_cnt + 32'd1;
      last_word_bad <= bad;
      if (bad && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
      if (bad && (kk == 3'd7))
        cs_bad_seen <= 1'b1;
      if ((kk == 3'd7) && blk_ok_cur && !bad)
        block_cnt <= block_cnt + 32'd1;
    end
  end

  assign locked = (state == LOCKED);
  assign status = {state, last_word_bad, cs_bad_seen};

`ifdef MEMFIFO_CHECKER_CAPTURE_EN
  logic captured;

  // Freeze the first mismatch seen since reset or clear
  always_ff @(posedge ifclk) begin
    if (reset || clear) begin
      captured      <= 1'b0;
      first_err_got <= 16'd0;
      first_err_exp <= 16'd0;
      first_err_idx <= 35'd0;
    end else if (check && bad && !captured) begin
      captured      <= 1'b1;
      first_err_got <= DI;
      first_err_exp <= exp_word;
      first_err_idx <= {word_cnt, kk};
    end
  end
`endif

endmodule
